// File: rtl/grid_input_ctrl_pkg.sv
// grid_input_ctrl_pkg
//   Shared definitions for the tic-tac-toe input processing unit:
//   FSM state encodings, board geometry defaults and the comparison-only
//   axis mapper used to turn a pixel coordinate into a row/column index.
//   No ports (package).
package grid_input_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAP      = 2'd1,
    REQ      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int GRID_CELLS = 9;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_GRID_X0         = 170;
  localparam int DEF_GRID_Y0         = 90;
  localparam int DEF_CELL_W          = 100;
  localparam int DEF_CELL_H          = 100;

  // Result of mapping one axis: hit=1 when the position lies on the board,
  // idx is then the 0..2 column (or row) index.
  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } axis_hit_t;

  // Three-band range check along one axis. All edges are formed in 11 bits
  // so origin + 3*size cannot wrap for any 10-bit screen coordinate.
  function automatic axis_hit_t axis_map(input logic [9:0]  pos,
                                         input logic [10:0] origin,
                                         input logic [10:0] size);
    logic [10:0] p;
    logic [10:0] e1;
    logic [10:0] e2;
    logic [10:0] e3;
    axis_hit_t   res;
    p   = {1'b0, pos};
    e1  = origin + size;
    e2  = e1 + size;
    e3  = e2 + size;
    res = '{hit: 1'b0, idx: 2'd0};
    if (p >= origin && p < e1) begin
      res = '{hit: 1'b1, idx: 2'd0};
    end else if (p >= e1 && p < e2) begin
      res = '{hit: 1'b1, idx: 2'd1};
    end else if (p >= e2 && p < e3) begin
      res = '{hit: 1'b1, idx: 2'd2};
    end
    return res;
  endfunction

endpackage

// File: rtl/grid_input_ctrl_btn_debounce.sv
// grid_input_ctrl_btn_debounce
//   Two-flop synchroniser, stability counter and press-edge pulse for the
//   raw click button.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous reset, active low
//     btn_raw  in   asynchronous button, 1 = pressed
//     level    out  debounced button level
//     press    out  one-cycle pulse when the debounced level rises 0->1
module grid_input_ctrl_btn_debounce
  import grid_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_vld1;
  logic             r_vld2;
  logic             r_armed;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
      r_armed <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      // r_vld2 marks r_sync2 as holding a real button sample rather than
      // the reset fill of the synchroniser.
      r_vld1  <= 1'b1;
      r_vld2  <= r_vld1;
      r_press <= 1'b0;

      // A button held down through reset must be seen released before
      // its debounced rise may count as a press.
      if (r_vld2 && !r_sync2) begin
        r_armed <= 1'b1;
      end

      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2 & r_armed;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/grid_input_ctrl.sv
// grid_input_ctrl
//   Input processing unit: debounces the click button, latches the cursor
//   at the press, maps it onto the 3x3 board and raises ipu_int until the
//   processor acknowledges.
//   Ports:
//     clk         in   system clock
//     rst         in   synchronous reset, active low
//     btn         in   raw click button, 1 = pressed
//     cursor_x    in   cursor pixel column 0..639
//     cursor_y    in   cursor pixel row 0..479
//     int_ack     in   interrupt acknowledge from the processor
//     ipu_int     out  interrupt request
//     grid_coord  out  cell index row*3+col, stable while ipu_int=1
module grid_input_ctrl
  import grid_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GRID_X0         = DEF_GRID_X0,
  parameter int GRID_Y0         = DEF_GRID_Y0,
  parameter int CELL_W          = DEF_CELL_W,
  parameter int CELL_H          = DEF_CELL_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [9:0] cursor_x,
  input  logic [9:0] cursor_y,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord
);

  localparam logic [10:0] X0 = 11'(GRID_X0);
  localparam logic [10:0] Y0 = 11'(GRID_Y0);
  localparam logic [10:0] CW = 11'(CELL_W);
  localparam logic [10:0] CH = 11'(CELL_H);

  state_t     r_state;
  state_t     w_state_next;
  logic [9:0] r_lat_x;
  logic [9:0] r_lat_y;
  logic [3:0] r_grid_coord;

  logic       w_level;
  logic       w_press;
  axis_hit_t  w_col;
  axis_hit_t  w_row;
  logic       w_inside;
  logic [3:0] w_cell;

  grid_input_ctrl_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn),
    .level  (w_level),
    .press  (w_press)
  );

  // Mapper works on the latched position, so the cursor may keep moving
  // while the MAP cycle evaluates.
  assign w_col    = axis_map(r_lat_x, X0, CW);
  assign w_row    = axis_map(r_lat_y, Y0, CH);
  assign w_inside = w_col.hit & w_row.hit;
  assign w_cell   = ({2'b00, w_row.idx} * 4'd3) + {2'b00, w_col.idx};

  // State register plus the position latch and cell register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lat_x      <= '0;
      r_lat_y      <= '0;
      r_grid_coord <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_press) begin
        r_lat_x <= cursor_x;
        r_lat_y <= cursor_y;
      end
      // Off-board clicks leave the previous cell visible.
      if (r_state == MAP && w_inside) begin
        r_grid_coord <= w_cell;
      end
    end
  end

  // Next-state logic. Presses outside IDLE are simply not looked at, and
  // WAIT_REL keeps a held button from producing a second request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_press) w_state_next = MAP;
      MAP:      w_state_next = w_inside ? REQ : IDLE;
      REQ:      if (int_ack) w_state_next = WAIT_REL;
      WAIT_REL: if (!w_level) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    ipu_int    = (r_state == REQ);
    grid_coord = r_grid_coord;
  end

endmodule
